wrr_row_arbiter: RTL and testbench
==================================

// Module: wrr_row_arbiter
// PURPOSE
//  Parametrised weighted round-robin row arbiter for the pixel hierarchy; next generation of the
//  level row arbiter. Grants one of NUM_ROWS row requests and holds it for up to a per-row burst
//  weight of acknowledged transfers. Supports continuous (wrapping) and single-pass (group) modes;
//  grp_release_o notifies the parent level when a pass is exhausted.
// PARAMETERS
//  NUM_ROWS  4                      number of row requesters (>=2)
//  ROW_ADD   $clog2(NUM_ROWS)       width of encoded grant index
//  WEIGHT_W  2                      width of each per-row burst weight
// PORTS
//  clk_i          in   1                  single clock, rising edge
//  reset_i        in   1                  synchronous, active-high reset
//  enable_i       in   1                  1 = FSM advances; 0 = full freeze (ack_i ignored)
//  refresh_i      in   1                  restart pass: mask <= all ones, abort grant
//  mode_i         in   1                  0 = continuous wrap, 1 = single pass
//  req_i          in   NUM_ROWS           active row requests
//  weight_i       in   NUM_ROWS*WEIGHT_W  burst weight of row i at [i*WEIGHT_W +: WEIGHT_W]; 0 = 1
//  ack_i          in   1                  consumer accepts current grant this cycle
//  gnt_o          out  NUM_ROWS           registered one-hot grant
//  gnt_valid_o    out  1                  gnt_o / xadd_o valid
//  xadd_o         out  ROW_ADD            index of granted row (registered with gnt_o)
//  grp_release_o  out  1                  pass-exhausted indication (see behaviour)
// BEHAVIOUR
//  Reset: gnt_o=0, gnt_valid_o=0, xadd_o=0, grp_release_o=0, mask=all ones, burst_cnt=0, state=ARB.
//  Priority per edge: reset_i > refresh_i > enable_i. refresh_i applies even when enable_i=0.
//  Eligible = req_i & mask. Pick = lowest-index eligible bit.
//  FSM states: ARB, GRANT, DONE.
//   ARB: eligible!=0 -> gnt_o=onehot(pick), xadd_o=pick, gnt_valid_o=1, burst_cnt=0, ->GRANT.
//        eligible==0, req_i!=0, mode 0 -> mask<=all ones, grp_release_o=1 for 1 cycle, stay ARB
//        (wrapped grant follows next cycle). eligible==0, mode 1 -> ->DONE.
//        req_i==0 -> stay ARB, no grant, no release pulse.
//   GRANT: gnt_o/xadd_o stable while ack_i=0 and req_i[cur]=1.
//        ack_i=1: burst_cnt+1; burst done when burst_cnt+1 == max(weight[cur],1).
//        burst done, or req_i[cur]=0 without ack -> mask<=ones<<(cur+1), gnt_o=0,
//        gnt_valid_o=0, ->ARB. Net: 1 idle cycle between consecutive grants.
//        ack_i=1 and req_i[cur]=0 same cycle -> ack counted, slot released (burst done).
//   DONE (mode 1 only): grp_release_o=1 (level), no grants, waits for refresh_i -> ARB.
//  refresh_i in any state: mask<=all ones, gnt_o=0, gnt_valid_o=0, burst_cnt=0,
//   grp_release_o=0, ->ARB. No ack is counted on that edge.
//  enable_i=0: all registers hold, ack_i ignored (consumer must not ack while frozen).
//  mode_i sampled only in ARB; change during GRANT takes effect at next ARB.
//  Mask after grant of highest row = 0 -> next ARB follows empty-eligible rules.
//  Grant latency: 1 cycle from ARB with eligible request to gnt_valid_o=1.
//  burst_cnt width WEIGHT_W; never wraps (burst ends at weight, max 2^WEIGHT_W-1).
//  gnt_o one-hot or zero at all times; gnt_valid_o == |gnt_o.
// TESTING
//  1 Reset: assert reset_i mid-GRANT -> next cycle gnt_o=0, gnt_valid_o=0, xadd_o=0, state ARB.
//  2 Weights: N=4, req=4'b1011, w={0,1,3,2} (row3..row0), ack every granted cycle, mode 0 ->
//    row0 x2, row1 x3, row3 x1 (weight 0 -> 1), release pulse, then row0 again.
//  3 Single pass: req=4'b0110, mode 1, ack always -> row1, row2, then grp_release_o=1 held;
//    refresh_i -> release drops, row1 granted again 2 cycles later.
//  4 Drop: row2 granted, w=3, req_i[2] falls after 1 ack -> grant cleared, next eligible row
//    (row3 if requesting) granted after 1 idle cycle.
//  5 Freeze: enable_i=0 while gnt_valid_o=1 with ack_i=1 for 3 cycles -> gnt_o, burst count
//    unchanged; refresh_i during freeze still clears grant and mask.
//  6 Random req/ack/weights, both modes -> one-hot check, xadd_o==index(gnt_o), no row
//    granted twice per pass in mode 1, every requesting row granted within one pass.

Source files
------------

// File: rtl/wrr_row_if.sv
// Handshake bundle between the weighted round-robin row arbiter and its requesters/consumer.
// The master side drives requests, weights and acks; the slave side is the arbiter.
interface wrr_row_if #(
  parameter int unsigned NUM_ROWS = 4,
  parameter int unsigned ROW_ADD  = $clog2(NUM_ROWS),
  parameter int unsigned WEIGHT_W = 2
);
  logic                         enable_i;
  logic                         refresh_i;
  logic                         mode_i;
  logic [NUM_ROWS-1:0]          req_i;
  logic [NUM_ROWS*WEIGHT_W-1:0] weight_i;
  logic                         ack_i;
  logic [NUM_ROWS-1:0]          gnt_o;
  logic                         gnt_valid_o;
  logic [ROW_ADD-1:0]           xadd_o;
  logic                         grp_release_o;

  modport master (
    output enable_i, refresh_i, mode_i, req_i, weight_i, ack_i,
    input  gnt_o, gnt_valid_o, xadd_o, grp_release_o
  );

  modport slave (
    input  enable_i, refresh_i, mode_i, req_i, weight_i, ack_i,
    output gnt_o, gnt_valid_o, xadd_o, grp_release_o
  );
endinterface

// File: rtl/wrr_row_arbiter.sv
// Weighted round-robin row arbiter: grants the lowest eligible row for up to its burst weight
// of acked transfers, in continuous (wrapping) or single-pass mode.
module wrr_row_arbiter #(
  parameter int unsigned NUM_ROWS = 4,
  parameter int unsigned ROW_ADD  = $clog2(NUM_ROWS),
  parameter int unsigned WEIGHT_W = 2
) (
  input  logic     clk_i,
  input  logic     reset_i,
  wrr_row_if.slave bus
);

  typedef enum logic [1:0] {StArb, StGrant, StDone} state_e;

  localparam logic [NUM_ROWS-1:0] AllOnes = '1;

  state_e              st_q, st_d;
  logic [NUM_ROWS-1:0] mask_q, mask_d;
  logic [NUM_ROWS-1:0] gnt_q, gnt_d;
  logic                gnt_valid_q, gnt_valid_d;
  logic [ROW_ADD-1:0]  xadd_q, xadd_d;
  logic                rel_q, rel_d;
  logic [WEIGHT_W-1:0] cnt_q, cnt_d;

  logic [NUM_ROWS-1:0] eligible;
  logic [ROW_ADD-1:0]  pick;
  logic [WEIGHT_W-1:0] cur_weight;
  logic [WEIGHT_W-1:0] burst_len;
  logic                cur_req;
  logic                burst_done;

  assign eligible   = bus.req_i & mask_q;
  assign cur_weight = bus.weight_i[int'(xadd_q)*WEIGHT_W +: WEIGHT_W];
  // A zero weight still grants a single transfer.
  assign burst_len  = (cur_weight == '0) ? WEIGHT_W'(1) : cur_weight;
  assign cur_req    = bus.req_i[xadd_q];
  assign burst_done = bus.ack_i && ((cnt_q + WEIGHT_W'(1)) == burst_len);

  // Lowest-index eligible row wins.
  always_comb begin
    pick = '0;
    for (int i = int'(NUM_ROWS) - 1; i >= 0; i--) begin
      if (eligible[i]) pick = ROW_ADD'(i);
    end
  end

  always_comb begin
    st_d        = st_q;
    mask_d      = mask_q;
    gnt_d       = gnt_q;
    gnt_valid_d = gnt_valid_q;
    xadd_d      = xadd_q;
    rel_d       = rel_q;
    cnt_d       = cnt_q;
    if (bus.refresh_i) begin
      st_d        = StArb;
      mask_d      = AllOnes;
      gnt_d       = '0;
      gnt_valid_d = 1'b0;
      cnt_d       = '0;
      rel_d       = 1'b0;
    end else if (bus.enable_i) begin
      case (st_q)
        StArb: begin
          rel_d = 1'b0;
          if (|eligible) begin
            gnt_d       = NUM_ROWS'(1) << pick;
            xadd_d      = pick;
            gnt_valid_d = 1'b1;
            cnt_d       = '0;
            st_d        = StGrant;
          end else if (|bus.req_i) begin
            rel_d = 1'b1;
            if (bus.mode_i) begin
              st_d = StDone;
            end else begin
              mask_d = AllOnes;
            end
          end
        end
        StGrant: begin
          if (burst_done || !cur_req) begin
            // Rows at or below the one just served sit out the rest of this pass.
            mask_d      = AllOnes << (int'(xadd_q) + 1);
            gnt_d       = '0;
            gnt_valid_d = 1'b0;
            cnt_d       = '0;
            st_d        = StArb;
          end else if (bus.ack_i) begin
            cnt_d = cnt_q + WEIGHT_W'(1);
          end
        end
        StDone: begin
          rel_d = 1'b1;
        end
        default: begin
          st_d = StArb;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      st_q        <= StArb;
      mask_q      <= AllOnes;
      gnt_q       <= '0;
      gnt_valid_q <= 1'b0;
      xadd_q      <= '0;
      rel_q       <= 1'b0;
      cnt_q       <= '0;
    end else begin
      st_q        <= st_d;
      mask_q      <= mask_d;
      gnt_q       <= gnt_d;
      gnt_valid_q <= gnt_valid_d;
      xadd_q      <= xadd_d;
      rel_q       <= rel_d;
      cnt_q       <= cnt_d;
    end
  end

  assign bus.gnt_o         = gnt_q;
  assign bus.gnt_valid_o   = gnt_valid_q;
  assign bus.xadd_o        = xadd_q;
  assign bus.grp_release_o = rel_q;

endmodule

// File: tb/tb_wrr_row_arbiter.sv
// Self-checking bench for wrr_row_arbiter: directed scenarios plus randomized passes,
// with grant/burst/release events scored against an expected-event queue.
module tb_wrr_row_arbiter;
  localparam int unsigned N  = 4;
  localparam int unsigned WW = 2;

  logic clk_i = 1'b0;
  logic reset_i;
  int   tests_run    = 0;
  int   tests_failed = 0;

  // Events: row*16 + acked transfers for a finished grant, -1 for a release rising edge.
  int   obs_q[$];
  int   exp_q[$];
  logic prev_valid = 1'b0;
  logic prev_rel   = 1'b0;
  int   cur_row    = 0;
  int   cur_acks   = 0;
  int   rel_cycles = 0;

  wrr_row_if #(.NUM_ROWS(N), .WEIGHT_W(WW)) bus ();

  wrr_row_arbiter #(.NUM_ROWS(N), .WEIGHT_W(WW)) dut (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .bus    (bus)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Advance one cycle and record events; inputs still hold the values seen at the edge.
  task automatic step();
    @(posedge clk_i);
    #1;
    if (bus.ack_i && prev_valid && bus.enable_i && !bus.refresh_i && !reset_i) cur_acks++;
    if (bus.gnt_valid_o && !prev_valid) begin
      cur_row  = int'(bus.xadd_o);
      cur_acks = 0;
    end
    if (!bus.gnt_valid_o && prev_valid) obs_q.push_back(cur_row * 16 + cur_acks);
    if (bus.grp_release_o && !prev_rel) obs_q.push_back(-1);
    if (bus.grp_release_o) rel_cycles++;
    prev_valid = bus.gnt_valid_o;
    prev_rel   = bus.grp_release_o;
  endtask

  task automatic idle_inputs();
    bus.enable_i  = 1'b1;
    bus.refresh_i = 1'b0;
    bus.mode_i    = 1'b0;
    bus.req_i     = '0;
    bus.weight_i  = '0;
    bus.ack_i     = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset_i = 1'b1;
    step();
    step();
    reset_i = 1'b0;
    obs_q.delete();
    exp_q.delete();
    rel_cycles = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset_i = 1'b1;
    step();
    tests_run++;
    if (bus.gnt_o !== 4'b0000 || bus.gnt_valid_o !== 1'b0 || bus.xadd_o !== 2'd0 ||
        bus.grp_release_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_values: gnt=%b valid=%b xadd=%0d rel=%b, want 0000/0/0/0",
               bus.gnt_o, bus.gnt_valid_o, bus.xadd_o, bus.grp_release_o);
    end
    reset_i      = 1'b0;
    bus.req_i    = 4'b0100;
    bus.weight_i = 8'hFF;
    step();
    tests_run++;
    if (bus.gnt_o !== 4'b0100 || bus.gnt_valid_o !== 1'b1 || bus.xadd_o !== 2'd2) begin
      tests_failed++;
      $display("FAIL reset_first_grant: gnt=%b valid=%b xadd=%0d, want 0100/1/2",
               bus.gnt_o, bus.gnt_valid_o, bus.xadd_o);
    end
    reset_i = 1'b1;
    step();
    tests_run++;
    if (bus.gnt_o !== 4'b0000 || bus.gnt_valid_o !== 1'b0 || bus.xadd_o !== 2'd0) begin
      tests_failed++;
      $display("FAIL reset_mid_grant: gnt=%b valid=%b xadd=%0d, want 0000/0/0",
               bus.gnt_o, bus.gnt_valid_o, bus.xadd_o);
    end
    reset_i = 1'b0;
    step();
    tests_run++;
    if (bus.gnt_valid_o !== 1'b1 || bus.xadd_o !== 2'd2) begin
      tests_failed++;
      $display("FAIL reset_rearb: valid=%b xadd=%0d, want 1/2", bus.gnt_valid_o, bus.xadd_o);
    end
  endtask

  task automatic test_weights();
    int e;
    int o;
    do_reset();
    bus.req_i    = 4'b1011;
    bus.weight_i = 8'b00_01_11_10;
    exp_q        = '{2, 19, 49, -1, 2};
    for (int c = 0; c < 60 && obs_q.size() < exp_q.size(); c++) begin
      step();
      bus.ack_i = bus.gnt_valid_o;
    end
    bus.ack_i = 1'b0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      tests_run++;
      if (obs_q.size() == 0) begin
        tests_failed++;
        $display("FAIL weights_event: got none (timeout), want %0d", e);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          tests_failed++;
          $display("FAIL weights_event: got %0d, want %0d", o, e);
        end
      end
    end
    tests_run++;
    if (rel_cycles != 1) begin
      tests_failed++;
      $display("FAIL weights_pulse_len: got %0d cycles, want 1", rel_cycles);
    end
  endtask

  task automatic test_single_pass();
    int e;
    int o;
    do_reset();
    bus.mode_i   = 1'b1;
    bus.req_i    = 4'b0110;
    bus.weight_i = 8'h00;
    exp_q        = '{17, 33, -1};
    for (int c = 0; c < 40 && obs_q.size() < exp_q.size(); c++) begin
      step();
      bus.ack_i = bus.gnt_valid_o;
    end
    bus.ack_i = 1'b0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      tests_run++;
      if (obs_q.size() == 0) begin
        tests_failed++;
        $display("FAIL single_event: got none (timeout), want %0d", e);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          tests_failed++;
          $display("FAIL single_event: got %0d, want %0d", o, e);
        end
      end
    end
    for (int c = 0; c < 3; c++) begin
      step();
      tests_run++;
      if (bus.grp_release_o !== 1'b1 || bus.gnt_valid_o !== 1'b0) begin
        tests_failed++;
        $display("FAIL single_done_hold: rel=%b valid=%b, want 1/0",
                 bus.grp_release_o, bus.gnt_valid_o);
      end
    end
    bus.refresh_i = 1'b1;
    step();
    bus.refresh_i = 1'b0;
    tests_run++;
    if (bus.grp_release_o !== 1'b0 || bus.gnt_valid_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL single_refresh: rel=%b valid=%b, want 0/0",
               bus.grp_release_o, bus.gnt_valid_o);
    end
    step();
    tests_run++;
    if (bus.gnt_valid_o !== 1'b1 || bus.xadd_o !== 2'd1) begin
      tests_failed++;
      $display("FAIL single_regrant: valid=%b xadd=%0d, want 1/1", bus.gnt_valid_o, bus.xadd_o);
    end
  endtask

  task automatic test_drop();
    int o;
    do_reset();
    bus.req_i    = 4'b1100;
    bus.weight_i = 8'b00_11_00_00;
    step();
    tests_run++;
    if (bus.gnt_valid_o !== 1'b1 || bus.xadd_o !== 2'd2) begin
      tests_failed++;
      $display("FAIL drop_grant: valid=%b xadd=%0d, want 1/2", bus.gnt_valid_o, bus.xadd_o);
    end
    bus.ack_i = 1'b1;
    step();
    tests_run++;
    if (bus.gnt_o !== 4'b0100) begin
      tests_failed++;
      $display("FAIL drop_hold: gnt=%b, want 0100", bus.gnt_o);
    end
    bus.ack_i = 1'b0;
    bus.req_i = 4'b1000;
    exp_q.push_back(33);
    step();
    tests_run++;
    if (bus.gnt_o !== 4'b0000 || bus.gnt_valid_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL drop_clear: gnt=%b valid=%b, want 0000/0", bus.gnt_o, bus.gnt_valid_o);
    end
    step();
    tests_run++;
    if (bus.gnt_valid_o !== 1'b1 || bus.xadd_o !== 2'd3) begin
      tests_failed++;
      $display("FAIL drop_next: valid=%b xadd=%0d, want 1/3", bus.gnt_valid_o, bus.xadd_o);
    end
    tests_run++;
    o = (obs_q.size() > 0) ? obs_q.pop_front() : -99;
    if (o !== exp_q.pop_front()) begin
      tests_failed++;
      $display("FAIL drop_burst: got %0d, want 33", o);
    end
  endtask

  task automatic test_freeze();
    do_reset();
    bus.req_i    = 4'b0011;
    bus.weight_i = 8'b00_00_11_01;
    step();
    bus.ack_i = 1'b1;
    step();
    bus.ack_i = 1'b0;
    step();
    tests_run++;
    if (bus.gnt_valid_o !== 1'b1 || bus.xadd_o !== 2'd1) begin
      tests_failed++;
      $display("FAIL freeze_setup: valid=%b xadd=%0d, want 1/1", bus.gnt_valid_o, bus.xadd_o);
    end
    bus.ack_i = 1'b1;
    step();
    bus.enable_i = 1'b0;
    for (int c = 0; c < 3; c++) begin
      step();
      tests_run++;
      if (bus.gnt_o !== 4'b0010 || bus.gnt_valid_o !== 1'b1) begin
        tests_failed++;
        $display("FAIL freeze_hold: gnt=%b valid=%b, want 0010/1", bus.gnt_o, bus.gnt_valid_o);
      end
    end
    bus.enable_i = 1'b1;
    step();
    tests_run++;
    if (bus.gnt_o !== 4'b0010 || bus.gnt_valid_o !== 1'b1) begin
      tests_failed++;
      $display("FAIL freeze_count: gnt=%b valid=%b, want 0010/1", bus.gnt_o, bus.gnt_valid_o);
    end
    bus.enable_i  = 1'b0;
    bus.ack_i     = 1'b0;
    bus.refresh_i = 1'b1;
    step();
    tests_run++;
    if (bus.gnt_o !== 4'b0000 || bus.gnt_valid_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL freeze_refresh: gnt=%b valid=%b, want 0000/0", bus.gnt_o, bus.gnt_valid_o);
    end
    bus.refresh_i = 1'b0;
    bus.enable_i  = 1'b1;
    step();
    tests_run++;
    if (bus.gnt_valid_o !== 1'b1 || bus.xadd_o !== 2'd0) begin
      tests_failed++;
      $display("FAIL freeze_mask: valid=%b xadd=%0d, want 1/0", bus.gnt_valid_o, bus.xadd_o);
    end
  endtask

  task automatic test_random();
    logic [N-1:0]    r;
    logic [N*WW-1:0] w;
    int              wi;
    int              e;
    int              o;
    do_reset();
    for (int mode = 0; mode < 2; mode++) begin
      for (int it = 0; it < 12; it++) begin
        r             = 4'($urandom_range(1, 15));
        w             = 8'($urandom);
        bus.mode_i    = 1'(mode);
        bus.req_i     = r;
        bus.weight_i  = w;
        bus.ack_i     = 1'b0;
        bus.refresh_i = 1'b1;
        step();
        bus.refresh_i = 1'b0;
        obs_q.delete();
        exp_q.delete();
        for (int i = 0; i < int'(N); i++) begin
          if (r[i]) begin
            wi = int'(w[i*WW +: WW]);
            exp_q.push_back(i * 16 + ((wi == 0) ? 1 : wi));
          end
        end
        exp_q.push_back(-1);
        for (int c = 0; c < 300 && obs_q.size() < exp_q.size(); c++) begin
          step();
          tests_run++;
          if ($countones(bus.gnt_o) > 1 || bus.gnt_valid_o !== (|bus.gnt_o) ||
              (bus.gnt_valid_o && bus.gnt_o !== (4'b0001 << bus.xadd_o))) begin
            tests_failed++;
            $display("FAIL rand_onehot: gnt=%b valid=%b xadd=%0d, want onehot matching",
                     bus.gnt_o, bus.gnt_valid_o, bus.xadd_o);
          end
          bus.ack_i = bus.gnt_valid_o & 1'($urandom_range(0, 1));
        end
        bus.ack_i = 1'b0;
        while (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          tests_run++;
          if (obs_q.size() == 0) begin
            tests_failed++;
            $display("FAIL rand_event: mode %0d req %b got none (timeout), want %0d", mode, r, e);
          end else begin
            o = obs_q.pop_front();
            if (o !== e) begin
              tests_failed++;
              $display("FAIL rand_event: mode %0d req %b w %b got %0d, want %0d",
                       mode, r, w, o, e);
            end
          end
        end
      end
    end
  endtask

  initial begin
    idle_inputs();
    reset_i = 1'b1;
    test_reset();
    test_weights();
    test_single_pass();
    test_drop();
    test_freeze();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
